// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the multi-master memory bus arbiter
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  // Value an unclaimed bus floats to; returned to a master whose access timed out.
  localparam logic [7:0] OPEN_BUS_BYTE = 8'hFF;

endpackage

// File: rtl/bus_arb_picker.sv
// rtl/bus_arb_picker.sv - combinational N-way picker, fixed lowest-index or round-robin from ptr+1
module bus_arb_picker
  import bus_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    if (rr_mode) begin
      // Walk ptr+1, ptr+2, ... wrapping, so the last winner is considered last.
      for (int k = 1; k <= N; k++) begin
        idx = PW'((int'(ptr) + k) % N);
        if (!valid && req[idx]) begin
          gnt[idx] = 1'b1;
          valid    = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!valid && req[i]) begin
          gnt[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - N-master to 1-slave bus arbiter with wait states, done/err handshake and timeout
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_done,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic                              s_read_en,
  output logic                              s_write_en,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_ready
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t             state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          pick_idx;
  logic [CW-1:0]          wait_cnt;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic                   timed_out;

  bus_arb_picker #(
    .N(NUM_MASTERS)
  ) u_picker (
    .req    (m_req & ~m_done),
    .ptr    (rr_ptr),
    .rr_mode(RR_MODE != 0),
    .gnt    (pick_gnt),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) pick_idx = IW'(i);
    end
  end

  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= IW'(NUM_MASTERS - 1);
      wait_cnt   <= '0;
      m_gnt      <= '0;
      m_done     <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_read_en  <= 1'b0;
      s_write_en <= 1'b0;
    end else begin
      m_done <= '0;
      m_err  <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            rr_ptr     <= pick_idx;
            m_gnt      <= pick_gnt;
            s_addr     <= m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata    <= m_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            s_write_en <= m_we[pick_idx];
            s_read_en  <= ~m_we[pick_idx];
            wait_cnt   <= '0;
            state      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (s_ready || timed_out) begin
            if (s_ready) begin
              if (s_read_en) m_rdata <= s_rdata;
            end else begin
              // Open-bus value (OPEN_BUS_BYTE replicated to the data width).
              m_rdata <= '1;
              m_err   <= m_gnt;
            end
            m_done     <= m_gnt;
            s_read_en  <= 1'b0;
            s_write_en <= 1'b0;
            state      <= ARB_DONE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ARB_DONE: begin
          m_gnt <= '0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed bench for bus_arbiter, round-robin and fixed-priority instances vs a model
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [DW-1:0]   s_rdata = '0;
  logic            s_ready = 1'b0;

  logic [N-1:0]  gnt_o[2];
  logic [N-1:0]  done_o[2];
  logic [N-1:0]  err_o[2];
  logic [DW-1:0] rdata_o[2];
  logic [AW-1:0] sa_o[2];
  logic [DW-1:0] swd_o[2];
  logic          sre_o[2];
  logic          swe_o[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(gnt_o[0]), .m_done(done_o[0]), .m_err(err_o[0]), .m_rdata(rdata_o[0]),
    .s_addr(sa_o[0]), .s_wdata(swd_o[0]), .s_read_en(sre_o[0]), .s_write_en(swe_o[0]),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(gnt_o[1]), .m_done(done_o[1]), .m_err(err_o[1]), .m_rdata(rdata_o[1]),
    .s_addr(sa_o[1]), .s_wdata(swd_o[1]), .s_read_en(sre_o[1]), .s_write_en(swe_o[1]),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one access in flight, its age in wait cycles, then a finishing cycle.
  bit            mb_busy[2], mb_fin[2], mb_err[2], mb_we[2];
  int            mb_own[2], mb_last[2], mb_age[2];
  logic [AW-1:0] mb_addr[2];
  logic [DW-1:0] mb_wdata[2], mb_rdata[2];

  function automatic int pick_rr(input int last, input logic [N-1:0] req);
    for (int j = last + 1; j < N; j++) if (req[j]) return j;
    for (int j = 0; j < N; j++) if (req[j]) return j;
    return 0;
  endfunction

  function automatic int pick_fixed(input logic [N-1:0] req);
    for (int j = 0; j < N; j++) if (req[j]) return j;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mb_busy[i] = 0; mb_fin[i] = 0; mb_err[i] = 0; mb_we[i] = 0;
        mb_own[i] = 0; mb_last[i] = N - 1; mb_age[i] = 0;
        mb_addr[i] = '0; mb_wdata[i] = '0; mb_rdata[i] = '0;
      end else if (mb_fin[i]) begin
        mb_fin[i] = 0;
        mb_err[i] = 0;
      end else if (mb_busy[i]) begin
        if (s_ready) begin
          mb_busy[i] = 0; mb_fin[i] = 1;
          if (!mb_we[i]) mb_rdata[i] = s_rdata;
        end else if (mb_age[i] + 1 == TO) begin
          mb_busy[i] = 0; mb_fin[i] = 1; mb_err[i] = 1; mb_rdata[i] = 8'hFF;
        end else begin
          mb_age[i]++;
        end
      end else if (m_req != '0) begin
        g = (i == 0) ? pick_rr(mb_last[i], m_req) : pick_fixed(m_req);
        mb_last[i]  = g;
        mb_own[i]   = g;
        mb_busy[i]  = 1;
        mb_age[i]   = 0;
        mb_we[i]    = m_we[g];
        mb_addr[i]  = m_addr[g*AW +: AW];
        mb_wdata[i] = m_wdata[g*DW +: DW];
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    for (int i = 0; i < 2; i++) begin
      eg = (mb_busy[i] || mb_fin[i]) ? N'(1 << mb_own[i]) : '0;
      chk($sformatf("gnt%0d", i), 32'(gnt_o[i]), 32'(eg));
      chk($sformatf("done%0d", i), 32'(done_o[i]), mb_fin[i] ? 32'(eg) : 32'h0);
      chk($sformatf("err%0d", i), 32'(err_o[i]), (mb_fin[i] && mb_err[i]) ? 32'(eg) : 32'h0);
      chk($sformatf("rdata%0d", i), 32'(rdata_o[i]), 32'(mb_rdata[i]));
      chk($sformatf("s_addr%0d", i), 32'(sa_o[i]), 32'(mb_addr[i]));
      chk($sformatf("s_wdata%0d", i), 32'(swd_o[i]), 32'(mb_wdata[i]));
      chk($sformatf("s_read_en%0d", i), 32'(sre_o[i]), 32'(mb_busy[i] && !mb_we[i]));
      chk($sformatf("s_write_en%0d", i), 32'(swe_o[i]), 32'(mb_busy[i] && mb_we[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_we[m]           = we;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
    m_req[m]          = 1'b1;
  endtask

  task automatic settle();
    m_req = '0;
    repeat (4) step();
  endtask

  task automatic wait_done(input int i, output logic [N-1:0] got);
    got = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done_o[i] != '0) begin
        got = done_o[i];
        break;
      end
    end
  endtask

  logic [N-1:0] exp_rr[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    int           wcnt, dcnt, bad, nrr, nfp, errseen;
    logic [N-1:0] lastdone, prev_rr, prev_fp, got;
    logic [N-1:0] seq_rr[6], seq_fp[6];

    step(); step();
    chk("reset_gnt", 32'(gnt_o[0]), 32'h0);
    chk("reset_done", 32'(done_o[0]), 32'h0);
    chk("reset_rdata", 32'(rdata_o[0]), 32'h0);
    chk("reset_strobes", 32'({sre_o[0], swe_o[0]}), 32'h0);
    rst_n = 1'b1;
    step();

    // Single read, ready in the first access cycle.
    s_ready = 1'b1; s_rdata = 8'h91;
    drive(0, 0, 16'hFF44, 8'h00);
    step();
    m_req = '0;
    chk("read_gnt", 32'(gnt_o[0]), 32'h1);
    chk("read_strobe", 32'(sre_o[0]), 32'h1);
    chk("read_addr", 32'(sa_o[0]), 32'hFF44);
    chk("read_done_early", 32'(done_o[0]), 32'h0);
    step();
    chk("read_done", 32'(done_o[0]), 32'h1);
    chk("read_rdata", 32'(rdata_o[0]), 32'h91);
    chk("read_strobe_off", 32'(sre_o[0]), 32'h0);
    step();
    chk("read_done_once", 32'(done_o[0]), 32'h0);
    settle();

    // Write with three wait cycles; ready coincides with the last pre-timeout cycle.
    s_ready = 1'b0;
    drive(1, 1, 16'hC000, 8'h5A);
    wcnt = 0; dcnt = 0; bad = 0; errseen = 0; lastdone = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) m_req = '0;
      if (c == 3) s_ready = 1'b1;
      if (swe_o[0]) begin
        wcnt++;
        if (swd_o[0] !== 8'h5A || sa_o[0] !== 16'hC000) bad++;
      end
      if (done_o[0] != '0) begin dcnt++; lastdone = done_o[0]; end
      if (err_o[0] != '0) errseen++;
    end
    chk("write_strobe_cycles", 32'(wcnt), 32'd4);
    chk("write_data_held", 32'(bad), 32'd0);
    chk("write_done_count", 32'(dcnt), 32'd1);
    chk("write_done_owner", 32'(lastdone), 32'h2);
    chk("write_no_err", 32'(errseen), 32'd0);
    chk("write_rdata_kept", 32'(rdata_o[0]), 32'h91);
    settle();

    // Reset in the middle of an access.
    s_ready = 1'b0;
    drive(0, 0, 16'h1234, 8'h00);
    step();
    m_req = '0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_gnt", 32'(gnt_o[0]), 32'h0);
    chk("midreset_strobe", 32'(sre_o[0]), 32'h0);
    chk("midreset_addr", 32'(sa_o[0]), 32'h0);
    chk("midreset_rdata", 32'(rdata_o[0]), 32'h0);
    step(); step();
    rst_n = 1'b1;
    dcnt = 0;
    repeat (6) begin
      step();
      if (done_o[0] != '0 || done_o[1] != '0) dcnt++;
    end
    chk("midreset_no_done", 32'(dcnt), 32'd0);

    // Continuous contention from all three masters.
    s_ready = 1'b1; s_rdata = 8'h27;
    drive(0, 0, 16'h0010, 8'h00);
    drive(1, 0, 16'h0011, 8'h00);
    drive(2, 0, 16'h0012, 8'h00);
    nrr = 0; nfp = 0; prev_rr = '0; prev_fp = '0;
    for (int k = 0; k < 6; k++) begin seq_rr[k] = '0; seq_fp[k] = '0; end
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt_o[0] != '0 && prev_rr == '0 && nrr < 6) begin seq_rr[nrr] = gnt_o[0]; nrr++; end
      if (gnt_o[1] != '0 && prev_fp == '0 && nfp < 6) begin seq_fp[nfp] = gnt_o[1]; nfp++; end
      prev_rr = gnt_o[0];
      prev_fp = gnt_o[1];
    end
    m_req = '0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_grant%0d", k), 32'(seq_rr[k]), 32'(exp_rr[k]));
      chk($sformatf("fixed_grant%0d", k), 32'(seq_fp[k]), 32'h1);
    end
    settle();

    // Master 2 drops its request right after being granted.
    s_ready = 1'b0; s_rdata = 8'h3C;
    drive(2, 0, 16'hABCD, 8'h00);
    step();
    m_req = '0;
    step();
    s_ready = 1'b1;
    wait_done(0, got);
    chk("drop_done", 32'(got), 32'h4);
    chk("drop_rdata", 32'(rdata_o[0]), 32'h3C);
    settle();

    // Timeout: slave never ready.
    s_ready = 1'b0;
    drive(0, 0, 16'h8000, 8'h00);
    step();
    m_req = '0;
    repeat (3) step();
    chk("timeout_not_early", 32'(done_o[0]), 32'h0);
    chk("timeout_strobe_last", 32'(sre_o[0]), 32'h1);
    step();
    chk("timeout_done", 32'(done_o[0]), 32'h1);
    chk("timeout_err", 32'(err_o[0]), 32'h1);
    chk("timeout_rdata", 32'(rdata_o[0]), 32'hFF);
    chk("timeout_err_fixed", 32'(err_o[1]), 32'h1);
    step();
    chk("timeout_err_clear", 32'(err_o[0]), 32'h0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
